// File: rtl/scope_pkg.sv
// Shared definitions for the capture/dump scope: RAM geometry and address type.
package scope_pkg;

  localparam int RAM_DEPTH = 384;
  localparam int ADDR_W    = 9;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t LAST_ADDR = addr_t'(RAM_DEPTH - 1);

endpackage

// File: rtl/circ_addr_inc.sv
// Circular increment over the capture RAM address space (0 .. RAM_DEPTH-1).
module circ_addr_inc
  import scope_pkg::*;
(
  input  addr_t addr,
  output addr_t next_addr
);

  // Anything at or beyond the top entry folds back to 0, so 384..511 never appear.
  always_comb begin
    if (addr >= LAST_ADDR) next_addr = '0;
    else                   next_addr = addr + addr_t'(1);
  end

endmodule

// File: rtl/dump_sequencer.sv
// Streams a completed circular capture buffer to a byte transmitter, oldest byte first.
module dump_sequencer
  import scope_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_dump,
  input  logic       capture_done,
  input  addr_t      last_addr,
  output logic       ram_en,
  output addr_t      ram_addr,
  input  logic [7:0] ram_rdata,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_done,
  output logic       dump_busy,
  output logic       dump_finished,
  output logic       clr_capture_done,
  output logic       dump_nak
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT_DATA,
    SEND,
    WAIT_TX,
    DONE
  } state_t;

  state_t     state, state_next;
  addr_t      ptr;
  addr_t      inc_in, inc_out;
  logic [8:0] cnt;
  logic       last_byte;
  logic       accept;

  assign accept    = (state == IDLE) && start_dump && capture_done;
  assign last_byte = (cnt == 9'(RAM_DEPTH - 1));

  // One incrementer: seeds the pointer from last_addr in IDLE, advances it otherwise.
  assign inc_in = (state == IDLE) ? last_addr : ptr;

  circ_addr_inc u_inc (
    .addr      (inc_in),
    .next_addr (inc_out)
  );

  // NOTE: async reset in the sensitivity list and <= for every flop keeps all state
  // updates race-free and lets rst_n override the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (accept) state_next = READ;
      READ:      state_next = WAIT_DATA;
      WAIT_DATA: state_next = SEND;
      SEND:      state_next = WAIT_TX;
      WAIT_TX:   if (tx_done) state_next = last_byte ? DONE : READ;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    ram_en           = (state == READ);
    tx_send          = (state == SEND);
    dump_busy        = (state != IDLE);
    dump_finished    = (state == DONE);
    clr_capture_done = (state == DONE);
  end

  assign ram_addr = ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      cnt      <= '0;
      tx_data  <= '0;
      dump_nak <= 1'b0;
    end else begin
      dump_nak <= (state == IDLE) && start_dump && !capture_done;
      unique case (state)
        IDLE: if (accept) begin
          ptr <= inc_out;
          cnt <= '0;
        end
        WAIT_DATA: tx_data <= ram_rdata;
        WAIT_TX: if (tx_done && !last_byte) begin
          ptr <= inc_out;
          cnt <= cnt + 9'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dump_sequencer.sv
// Directed bench for dump_sequencer with a RAM model and a byte-transmitter model.
module tb_dump_sequencer;
  import scope_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, start_dump, capture_done;
  addr_t      last_addr;
  logic       ram_en;
  addr_t      ram_addr;
  logic [7:0] ram_rdata, tx_data;
  logic       tx_send, tx_done, dump_busy, dump_finished, clr_capture_done, dump_nak;

  dump_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_dump       (start_dump),
    .capture_done     (capture_done),
    .last_addr        (last_addr),
    .ram_en           (ram_en),
    .ram_addr         (ram_addr),
    .ram_rdata        (ram_rdata),
    .tx_data          (tx_data),
    .tx_send          (tx_send),
    .tx_done          (tx_done),
    .dump_busy        (dump_busy),
    .dump_finished    (dump_finished),
    .clr_capture_done (clr_capture_done),
    .dump_nak         (dump_nak)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc;

  addr_t      addr_log[$];
  logic [7:0] send_log[$];
  int rd_count, send_count, fin_count, clr_count, nak_count;
  int first_rd_cyc, first_send_cyc, fin_cyc;
  int stable_err, dbl_send, rd_in_wait, coinc_err;
  bit pending, rd_pend;
  int wait_cnt, ack_delay;
  logic [7:0] hold_data;
  addr_t rd_addr;

  function automatic logic [7:0] mem_val(input addr_t a);
    return a[7:0] ^ {a[8], 7'h35};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    addr_log.delete();
    send_log.delete();
    rd_count = 0; send_count = 0; fin_count = 0; clr_count = 0; nak_count = 0;
    first_rd_cyc = -1; first_send_cyc = -1; fin_cyc = -1;
    stable_err = 0; dbl_send = 0; rd_in_wait = 0; coinc_err = 0;
    pending = 0; rd_pend = 0; wait_cnt = 0;
  endtask

  // One clock cycle: observe outputs at the falling edge, then update the RAM and transmitter models.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (ram_en) begin
      if (pending) rd_in_wait++;
      if (rd_count == 0) first_rd_cyc = cyc;
      rd_count++;
      addr_log.push_back(ram_addr);
    end
    if (tx_send) begin
      if (pending) dbl_send++;
      if (send_count == 0) first_send_cyc = cyc;
      send_count++;
      send_log.push_back(tx_data);
      pending   = 1;
      wait_cnt  = 0;
      hold_data = tx_data;
    end else if (pending && tx_data !== hold_data) begin
      stable_err++;
    end
    if (dump_finished) begin
      fin_count++;
      fin_cyc = cyc;
    end
    if (clr_capture_done) clr_count++;
    if (clr_capture_done !== dump_finished) coinc_err++;
    if (dump_nak) nak_count++;

    ram_rdata = rd_pend ? mem_val(rd_addr) : 8'hEE;
    rd_pend   = ram_en;
    rd_addr   = ram_addr;

    tx_done = 1'b0;
    if (pending && !tx_send) begin
      wait_cnt++;
      if (wait_cnt >= ack_delay) begin
        tx_done = 1'b1;
        pending = 0;
      end
    end
  endtask

  // mode 0: plain, 1: stray start_dump and tx_done, 2: tx_done with SEND, 3: reset at byte 200
  task automatic run_dump(input string tag, input addr_t last, input int delay, input int mode);
    bit done, aborted, inj_start;
    int budget;
    clear_logs();
    tick();
    ack_delay    = delay;
    last_addr    = last;
    capture_done = 1'b1;
    start_dump   = 1'b1;
    start_cyc    = cyc;
    done = 0; aborted = 0; inj_start = 0;
    budget = RAM_DEPTH * (delay + 4) + 20;
    for (int n = 0; n < budget && !done; n++) begin
      tick();
      start_dump = 1'b0;
      if (dump_finished) done = 1;
      if (mode == 1) begin
        if (send_count == 10 && !inj_start) begin
          start_dump = 1'b1;
          inj_start  = 1;
        end
        if (ram_en && send_count == 20) tx_done = 1'b1;
      end else if (mode == 2) begin
        if (tx_send) tx_done = 1'b1;
      end else if (mode == 3 && send_count == 200 && pending) begin
        aborted = 1;
        break;
      end
    end
    check({tag, ":completed"}, 32'(done | aborted), 32'd1);

    if (aborted) begin
      #2 rst_n = 1'b0;
      #1;
      check({tag, ":rst_busy"},   32'(dump_busy), 32'd0);
      check({tag, ":rst_ram_en"}, 32'(ram_en), 32'd0);
      check({tag, ":rst_send"},   32'(tx_send), 32'd0);
      check({tag, ":rst_txdata"}, 32'(tx_data), 32'd0);
      check({tag, ":rst_addr"},   32'(ram_addr), 32'd0);
      check({tag, ":rst_pulses"}, 32'({dump_finished, clr_capture_done, dump_nak}), 32'd0);
      clear_logs();
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      check({tag, ":no_finish"}, 32'(fin_count + clr_count), 32'd0);
      check({tag, ":idle_after"}, 32'(dump_busy), 32'd0);
    end
  endtask

  task automatic check_dump(input string tag, input addr_t last, input int delay);
    int order_err = 0;
    int data_err  = 0;
    for (int i = 0; i < addr_log.size(); i++)
      if (addr_log[i] !== addr_t'((last + 1 + i) % RAM_DEPTH)) order_err++;
    for (int i = 0; i < send_log.size(); i++)
      if (send_log[i] !== mem_val(addr_t'((last + 1 + i) % RAM_DEPTH))) data_err++;
    check({tag, ":reads"},      32'(rd_count), 32'(RAM_DEPTH));
    check({tag, ":sends"},      32'(send_count), 32'(RAM_DEPTH));
    check({tag, ":order"},      32'(order_err), 32'd0);
    check({tag, ":data"},       32'(data_err), 32'd0);
    check({tag, ":first_addr"}, (addr_log.size() > 0) ? 32'(addr_log[0]) : 32'hx,
          32'((last + 1) % RAM_DEPTH));
    check({tag, ":last_addr"},  (addr_log.size() > 0) ? 32'(addr_log[addr_log.size()-1]) : 32'hx,
          32'(last));
    check({tag, ":lat_ram_en"}, 32'(first_rd_cyc - start_cyc), 32'd1);
    check({tag, ":lat_send"},   32'(first_send_cyc - start_cyc), 32'd3);
    check({tag, ":lat_finish"}, 32'(fin_cyc - start_cyc), 32'(1 + (3 + delay) * RAM_DEPTH));
    check({tag, ":fin_pulses"}, 32'(fin_count), 32'd1);
    check({tag, ":clr_pulses"}, 32'(clr_count), 32'd1);
    check({tag, ":clr_coinc"},  32'(coinc_err), 32'd0);
    check({tag, ":tx_stable"},  32'(stable_err), 32'd0);
    check({tag, ":dbl_send"},   32'(dbl_send), 32'd0);
    check({tag, ":rd_in_wait"}, 32'(rd_in_wait), 32'd0);
    check({tag, ":nak"},        32'(nak_count), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    start_dump   = 1'b0;
    capture_done = 1'b0;
    last_addr    = '0;
    tx_done      = 1'b0;
    ram_rdata    = '0;
    ack_delay    = 1;
    clear_logs();
    #2;
    check("reset:busy",    32'(dump_busy), 32'd0);
    check("reset:outputs", 32'({ram_en, tx_send, dump_finished, clr_capture_done, dump_nak}), 32'd0);
    check("reset:addr",    32'(ram_addr), 32'd0);
    check("reset:tx_data", 32'(tx_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Rejected request: no capture available.
    clear_logs();
    tick();
    capture_done = 1'b0;
    start_dump   = 1'b1;
    tick();
    start_dump = 1'b0;
    check("nak:pulse", 32'(dump_nak), 32'd1);
    check("nak:busy",  32'(dump_busy), 32'd0);
    tick();
    check("nak:single", 32'(dump_nak), 32'd0);
    repeat (3) tick();
    check("nak:count",  32'(nak_count), 32'd1);
    check("nak:no_read", 32'(rd_count), 32'd0);
    check("nak:idle",   32'(dump_busy), 32'd0);

    run_dump("mid100", 9'd100, 1, 0);
    check_dump("mid100", 9'd100, 1);

    run_dump("top383", 9'd383, 1, 0);
    check_dump("top383", 9'd383, 1);

    run_dump("bot0", 9'd0, 1, 0);
    check_dump("bot0", 9'd0, 1);

    run_dump("slow", 9'd7, 50, 2);
    check_dump("slow", 9'd7, 50);

    run_dump("stray", 9'd200, 1, 1);
    check_dump("stray", 9'd200, 1);

    run_dump("abort", 9'd50, 1, 3);
    run_dump("resume", 9'd50, 1, 0);
    check_dump("resume", 9'd50, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dump_sequencer.md
DUMP_SEQUENCER -- requirements
Module: dump_sequencer

Interface
REQ-001 Parameter: none; depth SHALL come from package constant RAM_DEPTH = 384.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start_dump  input  1  single-cycle request to dump the captured buffer.
REQ-005 capture_done  input  1  level; buffer holds a complete capture.
REQ-006 last_addr  input  Address (9)  RAM address of final capture write; stable while capture_done=1.
REQ-007 ram_en  output  1  RAM read enable.
REQ-008 ram_addr  output  Address (9)  RAM read address.
REQ-009 ram_rdata  input  8  RAM read data, valid the cycle after ram_en.
REQ-010 tx_data  output  8  byte presented to transmitter; held stable from tx_send until tx_done.
REQ-011 tx_send  output  1  single-cycle pulse launching tx_data.
REQ-012 tx_done  input  1  single-cycle pulse; transmitter finished current byte.
REQ-013 dump_busy  output  1  high in every state except IDLE.
REQ-014 dump_finished  output  1  single-cycle pulse after last byte acknowledged.
REQ-015 clr_capture_done  output  1  single-cycle pulse, coincident with dump_finished.
REQ-016 dump_nak  output  1  single-cycle pulse when start_dump is rejected.

Function
REQ-017 States SHALL be IDLE, READ, WAIT_DATA, SEND, WAIT_TX, DONE.
REQ-018 IDLE: start_dump && capture_done -> READ; ptr := last_addr+1 (wrapped), cnt := 0.
REQ-019 IDLE: start_dump && !capture_done -> stay IDLE; dump_nak=1 next cycle only.
REQ-020 READ: ram_en=1, ram_addr=ptr for exactly one cycle -> WAIT_DATA.
REQ-021 WAIT_DATA: tx_data := ram_rdata -> SEND.
REQ-022 SEND: tx_send=1 for exactly one cycle -> WAIT_TX.
REQ-023 WAIT_TX: hold until tx_done; then cnt==RAM_DEPTH-1 -> DONE, else ptr := ptr+1 (wrapped), cnt := cnt+1 -> READ.
REQ-024 DONE: dump_finished=1, clr_capture_done=1 for one cycle -> IDLE.
REQ-025 Wrap: pointer increment from RAM_DEPTH-1 (383) SHALL yield 0; values 384..511 never driven.
REQ-026 Order: bytes SHALL be sent oldest first: last_addr+1 .. RAM_DEPTH-1, 0 .. last_addr; exactly RAM_DEPTH bytes per dump.
REQ-027 Latency: start_dump sampled at edge N -> ram_en high in cycle N+1, tx_send high in cycle N+3.
REQ-028 start_dump while dump_busy SHALL be ignored (no nak, no restart).
REQ-029 tx_done outside WAIT_TX SHALL be ignored.
REQ-030 tx_done in the same cycle as the SEND pulse SHALL NOT be accepted; acknowledgement counts only in WAIT_TX.
REQ-031 ram_addr SHALL equal ptr at all times; ram_en low outside READ.
REQ-032 cnt SHALL be 9 bits; it SHALL never exceed RAM_DEPTH-1.

Reset
REQ-033 rst_n low SHALL force IDLE immediately, regardless of the clock.
REQ-034 Reset values: ptr=0, cnt=0, tx_data=0, all outputs 0.
REQ-035 Reset mid-dump SHALL abandon the dump without pulsing dump_finished or clr_capture_done.

Structure
REQ-036 Address typedef (logic [8:0]) and RAM_DEPTH SHALL live in shared package scope_pkg; state enum stays local.
REQ-037 Wrapped increment SHALL be one combinational sub-module, circ_addr_inc, also usable by the capture writer.

Verification
REQ-038 capture_done=1, last_addr=100, tx_done one cycle after tx_send -> bytes from addresses 101..383, 0..100; dump_finished at cycle 1+4*384 after start.
REQ-039 last_addr=383 -> first ram_addr=0, last ram_addr=383; last_addr=0 -> first 1, last 0.
REQ-040 start_dump with capture_done=0 -> dump_nak pulse one cycle later, no ram_en, dump_busy stays 0.
REQ-041 tx_done held off 50 cycles per byte -> tx_data stable, no second tx_send, no ram_en until tx_done.
REQ-042 start_dump pulse at byte 10, and spurious tx_done during READ -> ignored; byte count still 384.
REQ-043 rst_n low at byte 200 -> all outputs 0 at once; no dump_finished; new dump after reset starts at last_addr+1.
